// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute-stage multiply/divide unit.
//   WIDTH      operand and HI/LO width
//   CNT_W      iteration counter width
//   md_op_t    MulDivOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   md_state_t sequencer states (IDLE, RUN, FIX)
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: datapath of the multiply/divide unit.
//   load      latch operand magnitudes, sign flags, op kind, divisor-zero flag
//   step      one shift-add (multiply) or restoring shift-subtract (divide) step
//   fix       sign-correct the result and write HI/LO; pulse div_zero next cycle
//   op        operation code of the instruction being loaded
//   src_a/b   forwarded operands (dividend / divisor)
//   hi/lo     architectural HI/LO registers
//   div_zero  one-cycle pulse after a divide by zero is written back
module muldiv_iter
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    // Multiply: {acc_hi, acc_lo} is the 2*WIDTH product accumulator, the
    // multiplier shifting out of acc_lo. Divide: acc_hi is the partial
    // remainder, acc_lo shifts the dividend out and the quotient in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic               ld_sign_a;
    logic               ld_sign_b;
    logic [WIDTH-1:0]   ld_a_mag;
    logic [WIDTH-1:0]   ld_b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        ld_sign_a = op_is_signed(op) & src_a[WIDTH-1];
        ld_sign_b = op_is_signed(op) & src_b[WIDTH-1];
        ld_a_mag  = ld_sign_a ? -src_a : src_a;
        ld_b_mag  = ld_sign_b ? -src_b : src_b;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);

        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_diff  = div_shift - {1'b0, b_mag};

        // Sign flags are only ever set for signed ops, so no op check here.
        prod_fix  = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                // Hand the dividend back exactly as it was presented.
                res_hi = sign_a ? -a_mag : a_mag;
                res_lo = '1;
            end else begin
                // Magnitude division makes MIN / -1 wrap back to MIN.
                res_hi = sign_a ? -acc_hi : acc_hi;
                res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            if (load) begin
                is_div <= op_is_div(op);
                sign_a <= ld_sign_a;
                sign_b <= ld_sign_b;
                b_zero <= (src_b == '0);
                a_mag  <= ld_a_mag;
                b_mag  <= ld_b_mag;
                acc_hi <= '0;
                acc_lo <= op_is_div(op) ? ld_a_mag : ld_b_mag;
            end else if (step) begin
                if (is_div) begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
            end
            if (fix) begin
                hi       <= res_hi;
                lo       <= res_lo;
                div_zero <= is_div & b_zero;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit and sequencer for the
// execute stage. Owns HI/LO and requests pipeline stalls while busy.
//   StartE/MulDivOpE/SrcAE/SrcBE  mul/div instruction and forwarded operands
//   FlushE                        execute bubble, qualifies StartE and MfReadE
//   MfReadE/HiSelE                mfhi/mflo in execute, HiSelE=1 selects HI
//   StallMDE                      stall request to the hazard unit
//   BusyE                         sequence in progress (RUN or FIX)
//   HiLoOutE                      selected HI/LO register value
//   HI/LO                         architectural registers
//   DivZeroE                      one-cycle pulse after a divide by zero
//   state_dbg                     sequencer state, for observation
//
// Handshake: an op is taken on any rising edge where StartE & ~FlushE and the
// unit is IDLE; while busy, a live StartE or MfReadE raises StallMDE and the
// pipeline holds the instruction until the unit returns to IDLE.
module muldiv_unit
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartE,
    input  logic [1:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    input  logic             MfReadE,
    input  logic             HiSelE,
    output logic             StallMDE,
    output logic             BusyE,
    output logic [WIDTH-1:0] HiLoOutE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZeroE,
    output md_state_t        state_dbg
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept    = StartE & ~FlushE & (state == IDLE);
    assign BusyE     = (state != IDLE);
    // A flushed slot carries no real instruction, so it never stalls.
    assign StallMDE  = BusyE & ~FlushE & (MfReadE | StartE);
    assign HiLoOutE  = HiSelE ? HI : LO;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state == RUN),
        .fix      (state == FIX),
        .op       (md_op_t'(MulDivOpE)),
        .src_a    (SrcAE),
        .src_b    (SrcBE),
        .hi       (HI),
        .lo       (LO),
        .div_zero (DivZeroE)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against a plain
// arithmetic reference model. Inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MulDivOpE = 2'b00;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        FlushE = 1'b0;
    logic        MfReadE = 1'b0;
    logic        HiSelE = 1'b0;
    logic        StallMDE;
    logic        BusyE;
    logic [31:0] HiLoOutE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivZeroE;
    mips_pkg::md_state_t state_dbg;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StartE    (StartE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .MfReadE   (MfReadE),
        .HiSelE    (HiSelE),
        .StallMDE  (StallMDE),
        .BusyE     (BusyE),
        .HiLoOutE  (HiLoOutE),
        .HI        (HI),
        .LO        (LO),
        .DivZeroE  (DivZeroE),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, HI, LO} from the architectural rules, using
    // native 64-bit and signed 32-bit arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return {1'b0, sp};
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {1'b0, 32'd0, 32'h8000_0000};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Runs one op starting at its cycle 0 (acceptance cycle) through cycle 34.
    // mf_cyc>0: mfhi held from that cycle on. hold: the next op (nop/na/nb) is
    // presented from cycle 20 and still held in cycle 34, where the task
    // returns; the next call then passes in_c0=1.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz,
                          input int mf_cyc, input bit hold, input logic [1:0] nop,
                          input logic [31:0] na, input logic [31:0] nb,
                          input bit in_c0, input bit rnd_flush);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        bit st;
        bit mf;
        bit fl;
        old_hi = exp_hi;
        old_lo = exp_lo;
        StartE = 1'b1;
        MulDivOpE = op;
        SrcAE = a;
        SrcBE = b;
        FlushE = 1'b0;
        if (!in_c0) begin
            MfReadE = 1'b1;
            HiSelE = 1'b1;
            @(negedge clk);
            chk("c0_busy", BusyE, 0);
            chk("c0_stall", StallMDE, 0);
            chk("c0_mf_old_hi", HiLoOutE, old_hi);
        end
        @(posedge clk); #1;
        for (int c = 1; c <= 33; c++) begin
            st = hold && (c >= 20);
            mf = (mf_cyc > 0) && (c >= mf_cyc);
            fl = rnd_flush && ($urandom_range(0, 3) == 0);
            StartE = st;
            if (st) begin
                MulDivOpE = nop;
                SrcAE = na;
                SrcBE = nb;
            end
            MfReadE = mf;
            HiSelE = 1'b1;
            FlushE = fl;
            @(negedge clk);
            chk("run_busy", BusyE, 1);
            chk("run_stall", StallMDE, (!fl && (mf || st)) ? 1 : 0);
            chk("run_hi_held", HI, old_hi);
            chk("run_lo_held", LO, old_lo);
            chk("run_dz", DivZeroE, 0);
            @(posedge clk); #1;
        end
        // cycle 34
        FlushE = 1'b0;
        StartE = hold;
        MfReadE = (mf_cyc > 0);
        HiSelE = 1'b1;
        @(negedge clk);
        exp_hi = e_hi;
        exp_lo = e_lo;
        chk("c34_busy", BusyE, 0);
        chk("c34_stall", StallMDE, 0);
        chk("c34_hi", HI, e_hi);
        chk("c34_lo", LO, e_lo);
        chk("c34_dz", DivZeroE, e_dz);
        chk("c34_out_hi", HiLoOutE, e_hi);
        HiSelE = 1'b0;
        #1;
        chk("c34_out_lo", HiLoOutE, e_lo);
        if (!hold) begin
            @(posedge clk); #1;
            StartE = 1'b0;
            MfReadE = 1'b0;
            @(negedge clk);
            chk("c35_dz", DivZeroE, 0);
            chk("c35_busy", BusyE, 0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t dir_v[8];

    initial begin
        logic [64:0] r1;
        logic [64:0] r2;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        dir_v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        dir_v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        dir_v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        dir_v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        dir_v[4] = '{2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        dir_v[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        dir_v[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        dir_v[7] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};

        // Reset state.
        #12;
        chk("rst_busy", BusyE, 0);
        chk("rst_stall", StallMDE, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_dz", DivZeroE, 0);
        chk("rst_out", HiLoOutE, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; the signed divide also carries an mfhi from cycle 5.
        for (int i = 0; i < 8; i++) begin
            run_op(dir_v[i].op, dir_v[i].a, dir_v[i].b, dir_v[i].hi, dir_v[i].lo, dir_v[i].dz,
                   (i == 3) ? 5 : 0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
        end

        // Flushed StartE is ignored.
        StartE = 1'b1;
        FlushE = 1'b1;
        MulDivOpE = 2'b01;
        SrcAE = 32'd3;
        SrcBE = 32'd4;
        @(negedge clk);
        chk("flush_stall", StallMDE, 0);
        @(posedge clk); #1;
        StartE = 1'b0;
        FlushE = 1'b0;
        @(negedge clk);
        chk("flush_busy", BusyE, 0);
        chk("flush_hi", HI, exp_hi);
        @(posedge clk); #1;

        // Back-to-back: next op held from cycle 20, accepted at the cycle-34 edge.
        r1 = ref_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        r2 = ref_model(2'b11, 32'd1000, 32'd3);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, r1[63:32], r1[31:0], r1[64],
               0, 1'b1, 2'b11, 32'd1000, 32'd3, 1'b0, 1'b0);
        run_op(2'b11, 32'd1000, 32'd3, r2[63:32], r2[31:0], r2[64],
               0, 1'b0, 2'b00, '0, '0, 1'b1, 1'b0);

        // Reset in cycle 10 of a MULTU.
        StartE = 1'b1;
        MulDivOpE = 2'b01;
        SrcAE = 32'hDEAD_BEEF;
        SrcBE = 32'h0000_0010;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("prerst_busy", BusyE, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", BusyE, 0);
        chk("midrst_hi", HI, 0);
        chk("midrst_lo", LO, 0);
        chk("midrst_stall", StallMDE, 0);
        chk("midrst_dz", DivZeroE, 0);
        chk("midrst_out", HiLoOutE, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        r1 = ref_model(2'b01, 32'h0001_0001, 32'h0002_0003);
        run_op(2'b01, 32'h0001_0001, 32'h0002_0003, r1[63:32], r1[31:0], r1[64],
               0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);

        // Random ops with random flush bubbles during RUN.
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            r1 = ref_model(rop, ra, rb);
            run_op(rop, ra, rb, r1[63:32], r1[31:0], r1[64],
                   (i % 4 == 1) ? int'($urandom_range(1, 33)) : 0,
                   1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
